// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg : shared types and encodings for the two-player score keeper
// Rev 1.0
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int SCORE_W = 2;

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    typedef logic [1:0] winner_t;

    // Bit 0 flags player 1, bit 1 flags player 2, so a tie is both bits set.
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;
    localparam winner_t WIN_TIE  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : synchroniser, debouncer and press-edge detector for one
// active-low push-button. Rev 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;

            // Comparing against DEBOUNCE_CYCLES-1 accepts on the N-th differing cycle.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : two-player 0..3 score keeper with PLAY/OVER game FSM feeding
// the seven-segment decoder. Rev 1.0
// ============================================================================
`default_nettype none

module score_keeper
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIN_SCORE       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_p1_n,
    input  logic               key_p2_n,
    input  logic               key_clr_n,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] c_win = SCORE_W'(WIN_SCORE);

    logic w_p1;
    logic w_p2;
    logic w_clr;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p1 (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_p1_n),
        .press (w_p1)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p2 (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_p2_n),
        .press (w_p2)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clr_n),
        .press (w_clr)
    );

    state_t             r_state;
    logic [SCORE_W-1:0] r_score1;
    logic [SCORE_W-1:0] r_score2;
    winner_t            r_winner;

    state_t             w_state_nxt;
    logic [SCORE_W-1:0] w_score1_nxt;
    logic [SCORE_W-1:0] w_score2_nxt;
    winner_t            w_winner_nxt;
    logic [SCORE_W-1:0] w_inc1;
    logic [SCORE_W-1:0] w_inc2;
    logic               w_hit1;
    logic               w_hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= PLAY;
            r_score1 <= '0;
            r_score2 <= '0;
            r_winner <= WIN_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_score1 <= w_score1_nxt;
            r_score2 <= w_score2_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    // Scores stay below WIN_SCORE while in PLAY, so a single increment cannot overshoot.
    always_comb begin
        w_state_nxt  = r_state;
        w_score1_nxt = r_score1;
        w_score2_nxt = r_score2;
        w_winner_nxt = r_winner;
        w_inc1       = r_score1 + SCORE_W'(w_p1);
        w_inc2       = r_score2 + SCORE_W'(w_p2);
        w_hit1       = (w_inc1 == c_win);
        w_hit2       = (w_inc2 == c_win);

        case (r_state)
            PLAY: begin
                if (w_clr) begin
                    w_score1_nxt = '0;
                    w_score2_nxt = '0;
                end else begin
                    w_score1_nxt = w_inc1;
                    w_score2_nxt = w_inc2;
                    if (w_hit1 || w_hit2) begin
                        w_state_nxt = OVER;
                        if (w_hit1 && w_hit2) begin
                            w_winner_nxt = WIN_TIE;
                        end else if (w_hit1) begin
                            w_winner_nxt = WIN_P1;
                        end else begin
                            w_winner_nxt = WIN_P2;
                        end
                    end
                end
            end
            OVER: begin
                if (w_clr) begin
                    w_state_nxt  = PLAY;
                    w_score1_nxt = '0;
                    w_score2_nxt = '0;
                    w_winner_nxt = WIN_NONE;
                end
            end
            default: begin
                w_state_nxt  = PLAY;
                w_score1_nxt = '0;
                w_score2_nxt = '0;
                w_winner_nxt = WIN_NONE;
            end
        endcase
    end

    always_comb begin
        score1    = r_score1;
        score2    = r_score2;
        winner    = r_winner;
        game_over = (r_state == OVER);
    end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// tb_score_keeper : directed and random button stimulus against a window-based
// behavioural model of the score keeper. Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int DEB  = 4;
    localparam int WIN  = 3;
    localparam int MAXE = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_p1_n = 1'b1;
    logic       key_p2_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic [1:0] score1;
    logic [1:0] score2;
    logic [1:0] winner;
    logic       game_over;

    score_keeper #(.DEBOUNCE_CYCLES(DEB), .WIN_SCORE(WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_p1_n  (key_p1_n),
        .key_p2_n  (key_p2_n),
        .key_clr_n (key_clr_n),
        .score1    (score1),
        .score2    (score2),
        .winner    (winner),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: button index 0 = p1, 1 = p2, 2 = clear; levels are "pressed".
    bit raw_h [3][MAXE];
    bit ev    [3][MAXE];
    bit acc   [3];
    int edge_i   = -1;
    int last_rst = -1;
    int m_s1 = 0, m_s2 = 0, m_win = 0;
    bit m_over = 1'b0;

    function automatic bit sample(input int b, input int idx);
        if (idx < 0 || idx <= last_rst) return 1'b0;
        return raw_h[b][idx];
    endfunction

    task automatic tick();
        bit cur [3];
        bit all_diff;
        @(posedge clk);
        edge_i++;
        cur[0] = ~key_p1_n;
        cur[1] = ~key_p2_n;
        cur[2] = ~key_clr_n;
        if (rst) begin
            last_rst = edge_i;
            for (int b = 0; b < 3; b++) begin
                raw_h[b][edge_i] = 1'b0;
                acc[b] = 1'b0;
                if (edge_i + 2 < MAXE) begin
                    ev[b][edge_i + 1] = 1'b0;
                    ev[b][edge_i + 2] = 1'b0;
                end
            end
            m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 1'b0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                raw_h[b][edge_i] = cur[b];
                // The accepted level flips once the last DEB synchronised samples all disagree with it.
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (sample(b, edge_i - 2 - k) == acc[b]) all_diff = 1'b0;
                if (all_diff) begin
                    acc[b] = ~acc[b];
                    if (acc[b] && edge_i + 2 < MAXE) ev[b][edge_i + 2] = 1'b1;
                end
            end
            if (ev[2][edge_i]) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 1'b0;
            end else if (!m_over) begin
                m_s1 += int'(ev[0][edge_i]);
                m_s2 += int'(ev[1][edge_i]);
                if (m_s1 == WIN || m_s2 == WIN) begin
                    m_over = 1'b1;
                    m_win  = (m_s1 == WIN ? 1 : 0) + (m_s2 == WIN ? 2 : 0);
                end
            end
        end
        #1;
        check_eq("score1", int'(score1), m_s1);
        check_eq("score2", int'(score2), m_s2);
        check_eq("winner", int'(winner), m_win);
        check_eq("game_over", int'(game_over), int'(m_over));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) key_p1_n = 1'b0; else if (b == 1) key_p2_n = 1'b0; else key_clr_n = 1'b0;
        ticks(hold);
        key_p1_n = 1'b1; key_p2_n = 1'b1; key_clr_n = 1'b1;
        ticks(hold);
    endtask

    initial begin : main
        int n;
        int hold_left [3];
        bit lvl [3];

        // Reset and idle.
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(100);
        check_eq("idle_score1", int'(score1), 0);
        check_eq("idle_game_over", int'(game_over), 0);

        // Short glitch, then a long hold with latency measurement.
        key_p1_n = 1'b0; ticks(3); key_p1_n = 1'b1; ticks(10);
        check_eq("glitch_score1", int'(score1), 0);
        key_p1_n = 1'b0;
        tick();
        n = 0;
        while (score1 != 2'd1 && n < 30) begin
            tick();
            n++;
        end
        check_eq("p1_latency", n, 7);
        ticks(20);
        key_p1_n = 1'b1;
        ticks(10);
        check_eq("hold_once", int'(score1), 1);

        // Reach the win, then p2 is ignored in OVER.
        press(0, 10); press(0, 10);
        check_eq("p1_wins", int'(winner), 1);
        press(1, 10);
        check_eq("over_p2_ignored", int'(score2), 0);

        // Clear, 2-2, simultaneous points give a tie.
        press(2, 10);
        check_eq("clr_game_over", int'(game_over), 0);
        press(0, 10); press(0, 10); press(1, 10); press(1, 10);
        key_p1_n = 1'b0; key_p2_n = 1'b0; ticks(12);
        key_p1_n = 1'b1; key_p2_n = 1'b1; ticks(10);
        check_eq("tie_winner", int'(winner), 3);

        // Clear from OVER, then clear coinciding with a p2 point.
        press(2, 10);
        press(1, 10);
        key_clr_n = 1'b0; key_p2_n = 1'b0; ticks(12);
        key_clr_n = 1'b1; key_p2_n = 1'b1; ticks(10);
        check_eq("clr_beats_p2", int'(score2), 0);

        // Reset mid-debounce of p2 with score1 = 2.
        press(0, 10); press(0, 10);
        key_p2_n = 1'b0; ticks(3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_score1", int'(score1), 0);
        key_p2_n = 1'b1;
        ticks(15);
        check_eq("rst_no_p2", int'(score2), 0);

        // Random key activity with occasional resets.
        for (int b = 0; b < 3; b++) begin
            hold_left[b] = 0;
            lvl[b] = 1'b0;
        end
        for (int c = 0; c < 6000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = (b == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
                    hold_left[b] = $urandom_range(1, 12);
                end
                hold_left[b]--;
            end
            key_p1_n  = ~lvl[0];
            key_p2_n  = ~lvl[1];
            key_clr_n = ~lvl[2];
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        key_p1_n = 1'b1; key_p2_n = 1'b1; key_clr_n = 1'b1;
        ticks(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_keeper.md
# score_keeper

Two-player score keeper that produces the pair of 2-bit scores shown on the seven-segment display stage. It conditions three raw board push-buttons (player 1 point, player 2 point, clear) with synchronisation, debouncing and press detection. It maintains each score 0..3 and runs a small game FSM that freezes play when either player reaches the winning score. Outputs feed the display decoder's two 2-bit inputs directly.

## Interface

- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz); legal range 1..2^20-1.
- WIN_SCORE, 3: score at which the game ends; legal range 1..3.

- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- key_p1_n  in  1  raw player-1 point button, active-low, asynchronous to clk.
- key_p2_n  in  1  raw player-2 point button, active-low, asynchronous to clk.
- key_clr_n  in  1  raw clear/new-game button, active-low, asynchronous to clk.
- score1  out  2  player-1 score, binary 0..3, to display decoder input 1.
- score2  out  2  player-2 score, binary 0..3, to display decoder input 2.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 tie.
- game_over  out  1  high while FSM is in OVER.

## Operation

- Per button, identical conditioning: two-flop synchroniser → debouncer → rising-edge detector on the debounced "pressed" level (pressed = raw low).
- Debouncer: counter clears whenever synchronised level equals accepted level. Otherwise it increments; on reaching DEBOUNCE_CYCLES the accepted level takes the synchronised level and the counter clears. Accepted level resets to "released".
- Press pulse: exactly one cycle per accepted release→pressed transition. Holding a button yields one pulse only. Release produces no pulse.
- FSM states: PLAY, OVER.
  - Reset state is PLAY.
  - PLAY: a p1 pulse increments score1 and a p2 pulse increments score2. Simultaneous p1/p2 pulses both apply in the same cycle.
  - PLAY → OVER: on the cycle either score reaches WIN_SCORE. winner = 01 or 10; 11 if both reach WIN_SCORE in the same cycle.
  - OVER: point pulses are ignored and scores are held. The clear pulse returns to PLAY with both scores 0 and winner 00.
  - Clear pulse in PLAY: scores go to 0 and the FSM stays in PLAY.
  - Clear together with a point pulse in the same cycle: clear wins and the point is discarded.
- Scores never exceed WIN_SCORE and never wrap from 3 to 0.
- winner and game_over are registered, consistent with state, and change only on entry to or exit from OVER.

## Timing

- Reset values: score1 = 00, score2 = 00, winner = 00, game_over = 0. Synchronisers reset to released, debounce counters to 0, edge detectors to released.
- rst has priority over all inputs. Asserting it mid-debounce or in OVER discards all in-flight state on the next edge.
- Latency: a raw press first sampled at edge N, held stable, produces a press pulse in cycle N+DEBOUNCE_CYCLES+2. The score, winner and game_over update at edge N+DEBOUNCE_CYCLES+3.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no pulse.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure

- Package score_pkg holds:
  - the state enum (PLAY, OVER);
  - the winner encodings (WIN_NONE, WIN_P1, WIN_P2, WIN_TIE);
  - the score width constant (2).
- Sub-module button_conditioner is instantiated three times. It contains the synchroniser, debouncer and edge detector, with parameter DEBOUNCE_CYCLES, inputs clk, rst, key_n and output press (one-cycle pulse).
- Top level holds the FSM, the score registers and the winner/game_over registers.

## Test plan

Run with DEBOUNCE_CYCLES = 4 and WIN_SCORE = 3.

1. Reset, no presses → score1 = score2 = 00, winner = 00 and game_over = 0, held for 100 cycles.
2. key_p1_n low for 3 cycles then high → no score change. Low for 20 cycles → score1 = 01 exactly 7 cycles after first sampled low; holding further produces no second increment.
3. Three clean p1 presses → score1 = 11, winner = 01, game_over = 1. A further p2 press leaves score2 = 00.
4. Scores at 2–2, p1 and p2 asserted on the same cycle → both scores = 11 on the same edge, winner = 11.
5. In OVER, a clear press → scores 00, winner 00, game_over 0. A clear press coinciding with a p2 pulse in PLAY at score2 = 01 → score2 = 00.
6. rst asserted for one cycle mid-debounce of p2 with score1 = 10 → all outputs return to reset values next edge, and no p2 increment follows.
